// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, writeback state enum and result-entry type
package alu_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;
  localparam int WB_CMP_W  = 8;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SHL = 4'h5;
  localparam logic [3:0] OP_SHR = 4'h6;
  localparam logic [3:0] OP_CMP = 4'h7;
  localparam logic [3:0] OP_MUL = 4'h8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR1  = 2'd1,
    WR2  = 2'd2
  } wb_state_t;

  typedef struct packed {
    logic [WB_DATA_W-1:0] y1;
    logic [WB_DATA_W-1:0] y2;
    logic [WB_ADDR_W-1:0] dst1;
    logic [WB_ADDR_W-1:0] dst2;
    logic                 wr2;
    logic [WB_CMP_W-1:0]  cmp;
    logic                 cmp_en;
  } result_entry_t;

endpackage

// File: rtl/alu_writeback_if.sv
// rtl/alu_writeback_if.sv - ALU result handshake into the writeback stage
interface alu_writeback_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CMP_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_y1;
  logic [DATA_W-1:0] in_y2;
  logic [ADDR_W-1:0] in_dst1;
  logic [ADDR_W-1:0] in_dst2;
  logic              in_wr2;
  logic [CMP_W-1:0]  in_cmp;
  logic              in_cmp_en;

  modport master (
    output in_valid, in_y1, in_y2, in_dst1, in_dst2, in_wr2, in_cmp, in_cmp_en,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_y1, in_y2, in_dst1, in_dst2, in_wr2, in_cmp, in_cmp_en,
    output in_ready
  );
endinterface

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - small synchronous FIFO of ALU result entries
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  result_entry_t wdata,
  output result_entry_t head,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  result_entry_t mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - buffers ALU results and serialises them onto the register-file write port
module alu_writeback
  import alu_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = 2,
  parameter int CMP_W  = WB_CMP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_writeback_if.slave    in_bus,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [CMP_W-1:0]  flags,
  output logic              busy
);

  result_entry_t in_entry;
  result_entry_t head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  wb_state_t         state, state_nxt;
  logic              y2_pend, y2_pend_nxt;
  logic              wb_en_nxt;
  logic [ADDR_W-1:0] wb_addr_nxt;
  logic [DATA_W-1:0] wb_data_nxt;
  logic [CMP_W-1:0]  flags_nxt;

  assign in_entry = '{
    y1:     in_bus.in_y1,
    y2:     in_bus.in_y2,
    dst1:   in_bus.in_dst1,
    dst2:   in_bus.in_dst2,
    wr2:    in_bus.in_wr2,
    cmp:    in_bus.in_cmp,
    cmp_en: in_bus.in_cmp_en
  };

  assign in_bus.in_ready = !full;
  assign push            = in_bus.in_valid && !full;
  assign busy            = !empty || (state != IDLE);

  alu_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (in_entry),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // Single-write entries leave the FIFO as their Y1 registers, so a full
  // FIFO drains without bubbles; two-write entries leave with their Y2.
  always_comb begin
    state_nxt   = IDLE;
    y2_pend_nxt = 1'b0;
    pop         = 1'b0;
    wb_en_nxt   = 1'b0;
    wb_addr_nxt = wb_addr;
    wb_data_nxt = wb_data;
    flags_nxt   = flags;
    if (state == WR1 && y2_pend) begin
      state_nxt   = WR2;
      pop         = 1'b1;
      wb_en_nxt   = 1'b1;
      wb_addr_nxt = head.dst2;
      wb_data_nxt = head.y2;
    end else if (!empty) begin
      state_nxt   = WR1;
      y2_pend_nxt = head.wr2;
      pop         = !head.wr2;
      wb_en_nxt   = 1'b1;
      wb_addr_nxt = head.dst1;
      wb_data_nxt = head.y1;
      if (head.cmp_en) flags_nxt = head.cmp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      y2_pend <= 1'b0;
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      flags   <= '0;
    end else begin
      state   <= state_nxt;
      y2_pend <= y2_pend_nxt;
      wb_en   <= wb_en_nxt;
      wb_addr <= wb_addr_nxt;
      wb_data <= wb_data_nxt;
      flags   <= flags_nxt;
    end
  end

endmodule
